// File: rtl/ss_seq_pkg.sv
// Shared types and constants for the save-state sequencer (ss_seq).
package ss_seq_pkg;

  // Read-only mapper-index register appended as the dump trailer.
  localparam logic [7:0] SS_IDX_ADDR = 8'd127;
  // Largest transfer length; keeps restore away from SS_IDX_ADDR.
  localparam logic [7:0] SS_LEN_MAX  = 8'd127;

  typedef enum logic [3:0] {
    SS_ST_IDLE,
    SS_ST_ARM,
    SS_ST_RD_SET,
    SS_ST_RD_WAIT,
    SS_ST_RD_PUSH,
    SS_ST_WR_PULL,
    SS_ST_WR_STRB,
    SS_ST_NEXT,
    SS_ST_TRAIL,
    SS_ST_FIN
  } ss_state_e;

  function automatic logic [7:0] ss_clamp_len(input logic [7:0] len);
    return (len > SS_LEN_MAX) ? SS_LEN_MAX : len;
  endfunction

  // CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] ss_crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/ss_seq_m2_edge.sv
// ss_m2_edge: brings the CPU M2 clock into the clk domain and flags its
// falling edge as a single-cycle pulse.
module ss_m2_edge
  import ss_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic m2_fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= m2;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign m2_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/ss_seq.sv
// ss_seq: save-state sequencer for the mapper register bank. Dumps registers
// 0..LEN-1 plus the mapper-index trailer to the host stream, or restores
// registers from the host stream with writes held until a synchronised M2 fall.
// Optional build macro: SS_CRC_EN adds an 8-bit crc output over transferred bytes.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned M2_TMO   = 4095,
  parameter logic [7:0]  IDX_ADDR = SS_IDX_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       cmd_start,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_len,
  input  logic       cmd_abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat
`ifdef SS_CRC_EN
  ,
  output logic [7:0] crc
`endif
);

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [11:0] TMO_LAST    = 12'(M2_TMO - 1);

  ss_state_e   state_q, state_d;
  logic [7:0]  addr_q,  addr_d;
  logic [7:0]  len_q,   len_d;
  logic        dir_q,   dir_d;
  logic        err_q,   err_d;
  logic        trail_q, trail_d;
  logic [3:0]  wait_q,  wait_d;
  logic [11:0] tmo_q,   tmo_d;
  logic [7:0]  dout_q,  dout_d;
  logic [7:0]  wdat_q,  wdat_d;
  logic        m2_fall;
  logic        active;

  ss_m2_edge u_m2_edge (
    .clk     (clk),
    .rst     (rst),
    .m2      (m2),
    .m2_fall (m2_fall)
  );

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    dir_d   = dir_q;
    err_d   = err_q;
    trail_d = trail_q;
    wait_d  = wait_q;
    tmo_d   = '0;
    dout_d  = dout_q;
    wdat_d  = wdat_q;
    if (state_q == SS_ST_IDLE) begin
      if (cmd_start) begin
        len_d   = ss_clamp_len(cmd_len);
        dir_d   = cmd_dir;
        err_d   = 1'b0;
        addr_d  = '0;
        trail_d = 1'b0;
        state_d = SS_ST_ARM;
      end
    end else if (state_q == SS_ST_FIN) begin
      addr_d  = '0;
      state_d = SS_ST_IDLE;
    end else if (cmd_abort) begin
      err_d   = 1'b1;
      state_d = SS_ST_FIN;
    end else begin
      case (state_q)
        SS_ST_ARM: begin
          if (m2_fall) begin
            if (len_q == 8'd0) state_d = dir_q ? SS_ST_FIN : SS_ST_TRAIL;
            else               state_d = dir_q ? SS_ST_WR_PULL : SS_ST_RD_SET;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = SS_ST_FIN;
          end else begin
            tmo_d = tmo_q + 12'd1;
          end
        end
        SS_ST_RD_SET: begin
          wait_d  = '0;
          state_d = SS_ST_RD_WAIT;
        end
        SS_ST_RD_WAIT: begin
          if (wait_q == SETTLE_LAST) begin
            dout_d  = ss_rdat;
            state_d = SS_ST_RD_PUSH;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        SS_ST_RD_PUSH: begin
          if (dout_rdy) state_d = trail_q ? SS_ST_FIN : SS_ST_NEXT;
        end
        SS_ST_WR_PULL: begin
          if (din_vld) begin
            wdat_d  = din;
            state_d = SS_ST_WR_STRB;
          end
        end
        SS_ST_WR_STRB: begin
          if (m2_fall) begin
            state_d = SS_ST_NEXT;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = SS_ST_FIN;
          end else begin
            tmo_d = tmo_q + 12'd1;
          end
        end
        SS_ST_NEXT: begin
          // Address is left on the last register so restore never touches IDX_ADDR.
          if (addr_q == len_q - 8'd1) begin
            state_d = dir_q ? SS_ST_FIN : SS_ST_TRAIL;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = dir_q ? SS_ST_WR_PULL : SS_ST_RD_SET;
          end
        end
        SS_ST_TRAIL: begin
          addr_d  = IDX_ADDR;
          trail_d = 1'b1;
          wait_d  = '0;
          state_d = SS_ST_RD_WAIT;
        end
        default: state_d = SS_ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SS_ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      trail_q <= 1'b0;
      wait_q  <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      trail_q <= trail_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      wdat_q  <= wdat_d;
    end
  end

  assign active   = (state_q != SS_ST_IDLE) && (state_q != SS_ST_FIN);
  assign busy     = active;
  assign ss_act   = active;
  assign done     = (state_q == SS_ST_FIN);
  assign err      = err_q;
  assign dout     = dout_q;
  assign dout_vld = (state_q == SS_ST_RD_PUSH);
  assign din_rdy  = (state_q == SS_ST_WR_PULL);
  // Abort pulls the strobe in the same cycle so the mapper never latches it.
  assign ss_we    = (state_q == SS_ST_WR_STRB) && !cmd_abort;
  assign ss_addr  = addr_q;
  assign ss_wdat  = wdat_q;

`ifdef SS_CRC_EN
  logic [7:0] crc_q, crc_d;

  // Running CRC over every byte crossing the host link, trailer included.
  always_comb begin
    crc_d = crc_q;
    if (state_q == SS_ST_IDLE && cmd_start)          crc_d = '0;
    else if (state_q == SS_ST_RD_PUSH && dout_rdy)   crc_d = ss_crc8(crc_q, dout_q);
    else if (state_q == SS_ST_WR_PULL && din_vld)    crc_d = ss_crc8(crc_q, din);
  end

  // CRC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
`endif

endmodule
